pipe_line_fetch: RTL and testbench

PIPE_LINE_FETCH -- requirements
Module: pipe_line_fetch

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_line_fetch_if.sv | 27 ++
 rtl/pipe_line_fetch.sv | 156 +++++++++++++++
 tb/tb_pipe_line_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and FSM state type for the pipe sprite line fetcher.
package pipe_pkg;

  localparam int unsigned SPR_W    = 20;
  localparam int unsigned SPR_H    = 40;
  localparam int unsigned N_PIPES  = 4;
  localparam int unsigned SCREEN_W = 640;

  localparam int unsigned RamAddrW = 19;
  localparam int unsigned LbAddrW  = 10;
  localparam int unsigned PixW     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StFetch,
    StDrain,
    StFinish
  } fetch_state_e;

endpackage

// File: rtl/pipe_line_fetch_if.sv
// Sprite RAM read port and line buffer write port as seen by the fetch unit.
interface pipe_line_fetch_if;
  import pipe_pkg::*;

  logic [RamAddrW-1:0] ram_read_addr;
  logic [PixW-1:0]     ram_data;
  logic                lb_we;
  logic [LbAddrW-1:0]  lb_addr;
  logic [PixW-1:0]     lb_data;

  modport master (
    output ram_read_addr,
    input  ram_data,
    output lb_we,
    output lb_addr,
    output lb_data
  );

  modport slave (
    input  ram_read_addr,
    output ram_data,
    input  lb_we,
    input  lb_addr,
    input  lb_data
  );

endinterface

// File: rtl/pipe_line_fetch.sv
// Walks the pipe list for one scanline, reads each hit pipe's sprite row from RAM and
// writes opaque, on-screen pixels into the line buffer (later pipes overwrite earlier).
module pipe_line_fetch #(
  parameter int unsigned SPR_W    = pipe_pkg::SPR_W,
  parameter int unsigned SPR_H    = pipe_pkg::SPR_H,
  parameter int unsigned N_PIPES  = pipe_pkg::N_PIPES,
  parameter int unsigned SCREEN_W = pipe_pkg::SCREEN_W
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    line_start,
  input  logic [9:0]              next_y,
  input  logic [N_PIPES-1:0]      pipe_en,
  input  logic [N_PIPES-1:0]      pipe_flip,
  input  logic [N_PIPES-1:0][9:0] pipe_x,
  input  logic [N_PIPES-1:0][9:0] pipe_y,
  pipe_line_fetch_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  import pipe_pkg::*;

  localparam int unsigned IdxW = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam int unsigned ColW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_PIPES - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(SPR_W - 1);

  fetch_state_e state_q, state_d;

  logic [9:0]              ny_q;
  logic [N_PIPES-1:0]      en_q, flip_q;
  logic [N_PIPES-1:0][9:0] x_q, y_q;
  logic [IdxW-1:0]         idx_q;
  logic [ColW-1:0]         col_q;
  logic [RamAddrW-1:0]     addr_q;
  logic                    cap_valid_q;
  logic [LbAddrW:0]        cap_x_q;
  logic                    lb_we_q;
  logic [LbAddrW-1:0]      lb_addr_q;
  logic [PixW-1:0]         lb_data_q;
  logic                    overrun_q;

  logic                hit, last_pipe, last_col;
  logic [9:0]          row_raw, row;
  logic [RamAddrW-1:0] base_addr;
  logic [LbAddrW:0]    pix_x;

  always_comb begin
    row_raw   = ny_q - y_q[idx_q];
    row       = flip_q[idx_q] ? (10'(SPR_H - 1) - row_raw) : row_raw;
    // 11-bit upper bound so pipes near the bottom of the y range do not wrap
    hit       = en_q[idx_q] && (ny_q >= y_q[idx_q]) &&
                ({1'b0, ny_q} < ({1'b0, y_q[idx_q]} + 11'(SPR_H)));
    base_addr = RamAddrW'(row) * RamAddrW'(SPR_W);
    last_pipe = (idx_q == LastIdx);
    last_col  = (col_q == LastCol);
    pix_x     = {1'b0, x_q[idx_q]} + 11'(col_q);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (line_start) state_d = StCheck;
      StCheck: begin
        if (hit)            state_d = StFetch;
        else if (last_pipe) state_d = StFinish;
      end
      StFetch:  if (last_col) state_d = StDrain;
      StDrain:  state_d = last_pipe ? StFinish : StCheck;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFinish);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ny_q        <= '0;
      en_q        <= '0;
      flip_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_x_q     <= '0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (line_start && (state_q != StIdle)) overrun_q <= 1'b1;

      // RAM data lags the address by one cycle; column travels with it
      cap_valid_q <= (state_q == StFetch);
      cap_x_q     <= pix_x;
      lb_we_q     <= cap_valid_q && (bus.ram_data != '0) && (cap_x_q < 11'(SCREEN_W));
      if (cap_valid_q) begin
        lb_addr_q <= cap_x_q[LbAddrW-1:0];
        lb_data_q <= bus.ram_data;
      end

      case (state_q)
        StIdle: begin
          if (line_start) begin
            ny_q   <= next_y;
            en_q   <= pipe_en;
            flip_q <= pipe_flip;
            x_q    <= pipe_x;
            y_q    <= pipe_y;
            idx_q  <= '0;
          end
        end
        StCheck: begin
          if (hit) begin
            col_q  <= '0;
            addr_q <= base_addr;
          end else if (!last_pipe) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StFetch: begin
          if (!last_col) begin
            col_q  <= col_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        StDrain: begin
          if (!last_pipe) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_read_addr = addr_q;
  assign bus.lb_we         = lb_we_q;
  assign bus.lb_addr       = lb_addr_q;
  assign bus.lb_data       = lb_data_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_pipe_line_fetch.sv
// Bench for pipe_line_fetch: directed and randomized scanlines checked every cycle against
// a schedule derived from the pipe list and the sprite RAM contents.
module tb_pipe_line_fetch;

  localparam int NP   = 4;
  localparam int SW   = 20;
  localparam int SH   = 40;
  localparam int SCR  = 640;
  localparam int MAXT = 128;

  logic               CLK = 1'b0;
  logic               Reset;
  logic               line_start;
  logic [9:0]         next_y;
  logic [NP-1:0]      pipe_en;
  logic [NP-1:0]      pipe_flip;
  logic [NP-1:0][9:0] pipe_x;
  logic [NP-1:0][9:0] pipe_y;
  logic               busy;
  logic               done;
  logic               overrun;

  pipe_line_fetch_if bus ();

  pipe_line_fetch #(
    .SPR_W   (SW),
    .SPR_H   (SH),
    .N_PIPES (NP),
    .SCREEN_W(SCR)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .line_start(line_start),
    .next_y    (next_y),
    .pipe_en   (pipe_en),
    .pipe_flip (pipe_flip),
    .pipe_x    (pipe_x),
    .pipe_y    (pipe_y),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  logic [3:0] mem [0:1023];
  always @(posedge CLK) bus.ram_data <= mem[bus.ram_read_addr[9:0]];

  // Expected schedule, indexed by cycles since the line_start cycle
  bit exp_we  [MAXT];
  int exp_lba [MAXT];
  int exp_lbd [MAXT];
  bit exp_av  [MAXT];
  int exp_addr[MAXT];
  int exp_d;

  int         n_chk, n_pass;
  bit         track;
  int         toff, done_at, wr_cnt;
  int         addr_log[MAXT];
  logic [3:0] lb_dut [0:1023];

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, expv);
  endtask

  // Each pipe costs one check cycle, plus SPR_W fetches and a drain cycle when it hits.
  task automatic build_model();
    int s = 1;
    for (int t = 0; t < MAXT; t++) begin
      exp_we[t] = 0; exp_lba[t] = 0; exp_lbd[t] = 0; exp_av[t] = 0; exp_addr[t] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      int ny = int'(next_y);
      int py = int'(pipe_y[p]);
      int px = int'(pipe_x[p]);
      if (pipe_en[p] && ny >= py && ny < py + SH) begin
        int row = pipe_flip[p] ? (SH - 1 - (ny - py)) : (ny - py);
        for (int c = 0; c < SW; c++) begin
          int a = row * SW + c;
          exp_av[s + 1 + c]   = 1;
          exp_addr[s + 1 + c] = a;
          if (mem[a] != 4'd0 && px + c < SCR) begin
            exp_we[s + 3 + c]  = 1;
            exp_lba[s + 3 + c] = px + c;
            exp_lbd[s + 3 + c] = int'(mem[a]);
          end
        end
        s += SW + 2;
      end else begin
        s += 1;
      end
    end
    exp_d = s;
  endtask

  task automatic compare_cycle();
    check("busy", int'(busy), int'(toff >= 1 && toff <= exp_d));
    check("done", int'(done), int'(toff == exp_d));
    check("lb_we", int'(bus.lb_we), int'(exp_we[toff]));
    if (exp_we[toff]) begin
      check("lb_addr", int'(bus.lb_addr), exp_lba[toff]);
      check("lb_data", int'(bus.lb_data), exp_lbd[toff]);
    end
    if (exp_av[toff]) check("ram_read_addr", int'(bus.ram_read_addr), exp_addr[toff]);
    if (bus.lb_we) begin
      lb_dut[bus.lb_addr] = bus.lb_data;
      wr_cnt++;
    end
    if (done) done_at = toff;
    addr_log[toff] = int'(bus.ram_read_addr);
    toff++;
    if (toff > exp_d + 1 || toff >= MAXT) track = 0;
  endtask

  task automatic tick();
    @(negedge CLK);
    if (track) compare_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic randomize_inputs();
    next_y = 10'($urandom_range(0, 1023));
    for (int p = 0; p < NP; p++) begin
      pipe_en[p]   = ($urandom_range(0, 3) != 0);
      pipe_flip[p] = 1'($urandom_range(0, 1));
      pipe_y[p]    = 10'((32'(next_y) - $urandom_range(0, 50)) & 32'h3ff);
      pipe_x[p]    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 639))
                                                 : 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endtask

  task automatic fill_mem(input logic [3:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  // Launches one line; ovr_at pulses line_start mid-line, stop_at abandons tracking early.
  task automatic run_line(input bit scramble, input int ovr_at, input int stop_at);
    int k = 0;
    build_model();
    for (int i = 0; i < 1024; i++) lb_dut[i] = 4'd0;
    wr_cnt = 0; done_at = -1; toff = 0; track = 1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    if (scramble) randomize_inputs();
    while (track && k < 300) begin
      if (toff == stop_at) begin
        track = 0;
      end else begin
        line_start = (toff == ovr_at);
        tick();
        k++;
      end
    end
    line_start = 1'b0;
    if (track) begin
      n_chk++;
      $display("FAIL line_timeout: no completion after %0d cycles", k);
      track = 0;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; track = 0; toff = 0;
    Reset = 1'b1; line_start = 1'b0; next_y = '0;
    pipe_en = '0; pipe_flip = '0; pipe_x = '0; pipe_y = '0;
    fill_mem(4'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_lb_we", int'(bus.lb_we), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_ram_addr", int'(bus.ram_read_addr), 0);
    check("rst_lb_addr", int'(bus.lb_addr), 0);
    check("rst_lb_data", int'(bus.lb_data), 0);
    Reset = 1'b0;
    tick();

    // Single pipe, sprite row 0 all colour 5
    fill_mem(4'd0);
    for (int c = 0; c < SW; c++) mem[c] = 4'd5;
    pipe_en = 4'b0001; pipe_x[0] = 10'd100; pipe_y[0] = 10'd50; next_y = 10'd50;
    run_line(0, -1, -1);
    check("a_writes", wr_cnt, 20);
    check("a_done_at", done_at, 26);
    check("a_lb100", int'(lb_dut[100]), 5);
    check("a_lb119", int'(lb_dut[119]), 5);
    check("a_lb120", int'(lb_dut[120]), 0);

    // Vertical mirror on row 0 reads the last sprite row
    fill_mem_random();
    pipe_en = 4'b0001; pipe_flip = 4'b0001; pipe_x[0] = 10'd0; pipe_y[0] = 10'd0; next_y = 10'd0;
    run_line(0, -1, -1);
    check("b_first_addr", addr_log[2], 780);
    check("b_last_addr", addr_log[21], 799);
    pipe_flip = '0;

    // Right screen edge clipping
    fill_mem(4'd9);
    pipe_en = 4'b0001; pipe_x[0] = 10'd630; pipe_y[0] = 10'd200; next_y = 10'd200;
    run_line(0, -1, -1);
    check("c_writes", wr_cnt, 10);
    check("c_lb630", int'(lb_dut[630]), 9);
    check("c_lb639", int'(lb_dut[639]), 9);

    // Overlapping pipes plus a line_start while busy
    fill_mem(4'd0);
    for (int c = 0; c < SW; c++) begin
      mem[c] = 4'd3;
      mem[SW + c] = 4'd7;
    end
    pipe_en = 4'b0011; next_y = 10'd50;
    pipe_x[0] = 10'd100; pipe_y[0] = 10'd50;
    pipe_x[1] = 10'd110; pipe_y[1] = 10'd49;
    check("d_overrun_pre", int'(overrun), 0);
    run_line(0, 10, -1);
    check("d_overrun", int'(overrun), 1);
    check("d_lb100", int'(lb_dut[100]), 3);
    check("d_lb109", int'(lb_dut[109]), 3);
    check("d_lb110", int'(lb_dut[110]), 7);
    check("d_lb119", int'(lb_dut[119]), 7);
    check("d_lb129", int'(lb_dut[129]), 7);

    // Nothing enabled
    pipe_en = '0;
    run_line(0, -1, -1);
    check("e_model_d", exp_d, 5);
    check("e_done_at", done_at, 5);
    check("e_writes", wr_cnt, 0);

    // Every pipe hits
    fill_mem_random();
    pipe_en = 4'b1111; next_y = 10'd300;
    for (int p = 0; p < NP; p++) begin
      pipe_y[p] = 10'(290 + p);
      pipe_x[p] = 10'(50 * p);
    end
    run_line(0, -1, -1);
    check("f_done_at", done_at, 89);

    for (int n = 0; n < 25; n++) begin
      fill_mem_random();
      randomize_inputs();
      run_line(1, -1, -1);
    end

    // Reset in the middle of a fetch with writes in flight
    fill_mem(4'd9);
    pipe_en = 4'b0001; pipe_flip = '0; pipe_x[0] = 10'd100; pipe_y[0] = 10'd300;
    next_y = 10'd300;
    run_line(0, -1, 8);
    Reset = 1'b1;
    tick();
    check("r_busy", int'(busy), 0);
    check("r_lb_we", int'(bus.lb_we), 0);
    check("r_done", int'(done), 0);
    check("r_overrun", int'(overrun), 0);
    check("r_ram_addr", int'(bus.ram_read_addr), 0);
    Reset = 1'b0;
    tick();
    check("r_lb_we_next", int'(bus.lb_we), 0);
    check("r_busy_next", int'(busy), 0);
    run_line(0, -1, -1);
    check("r_recover_writes", wr_cnt, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
